// File: rtl/demod_segment_decider_if.sv
// Sample/reference input bus and decided-bit output bus
// for the segment decider.
interface demod_segment_decider_if #(
    parameter int DATA_W = 32
);
    logic              start;
    logic [DATA_W-1:0] sample_in;
    logic              sample_valid;
    logic [DATA_W-1:0] ref_in;
    logic [DATA_W-1:0] ref_m_in;
    logic              bit_out;
    logic              valid;
    logic              busy;

    modport master (
        output start, sample_in, sample_valid, ref_in, ref_m_in,
        input  bit_out, valid, busy
    );

    modport slave (
        input  start, sample_in, sample_valid, ref_in, ref_m_in,
        output bit_out, valid, busy
    );
endinterface

// File: rtl/demod_segment_decider.sv
// Per-segment bit decision: sums |sample-ref| against both
// candidate waveforms and picks the closer one.
module demod_segment_decider #(
    parameter int DATA_W  = 32,
    parameter int SEG_LEN = 16,
    parameter int CNT_W   = $clog2(SEG_LEN) + 1,
    parameter int ACC_W   = DATA_W + 1 + $clog2(SEG_LEN)
) (
    input logic clk,
    input logic reset,
    demod_segment_decider_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DECIDE,
        DONE
    } state_t;

    state_t             state;
    logic [ACC_W-1:0]   dist_p;
    logic [ACC_W-1:0]   dist_m;
    logic [CNT_W-1:0]   cnt;
    logic               bit_r;
    logic               valid_r;
    logic               busy_r;

    logic signed [DATA_W:0] diff_p;
    logic signed [DATA_W:0] diff_m;
    logic [DATA_W:0]        mag_p;
    logic [DATA_W:0]        mag_m;

    // Sign-extended differences and their magnitudes; one extra bit
    // keeps full-scale opposite-sign inputs from wrapping.
    always_comb begin
        diff_p = {bus.sample_in[DATA_W-1], bus.sample_in}
               - {bus.ref_in[DATA_W-1], bus.ref_in};
        diff_m = {bus.sample_in[DATA_W-1], bus.sample_in}
               - {bus.ref_m_in[DATA_W-1], bus.ref_m_in};
        mag_p  = diff_p[DATA_W] ? $unsigned(-diff_p) : $unsigned(diff_p);
        mag_m  = diff_m[DATA_W] ? $unsigned(-diff_m) : $unsigned(diff_m);
    end

    // Segment FSM with registered handshake outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            dist_p  <= '0;
            dist_m  <= '0;
            cnt     <= '0;
            bit_r   <= 1'b0;
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    valid_r <= 1'b0;
                    if (bus.start) begin
                        state  <= ACCUM;
                        dist_p <= '0;
                        dist_m <= '0;
                        cnt    <= '0;
                        busy_r <= 1'b1;
                    end
                end
                ACCUM: begin
                    if (bus.sample_valid) begin
                        dist_p <= dist_p + ACC_W'(mag_p);
                        dist_m <= dist_m + ACC_W'(mag_m);
                        cnt    <= cnt + CNT_W'(1);
                        if (cnt == CNT_W'(SEG_LEN - 1)) begin
                            state <= DECIDE;
                        end
                    end
                end
                DECIDE: begin
                    bit_r   <= (dist_p < dist_m);
                    valid_r <= 1'b1;
                    busy_r  <= 1'b0;
                    state   <= DONE;
                end
                DONE: begin
                    valid_r <= 1'b0;
                    if (bus.start) begin
                        state  <= ACCUM;
                        dist_p <= '0;
                        dist_m <= '0;
                        cnt    <= '0;
                        busy_r <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.bit_out = bit_r;
    assign bus.valid   = valid_r;
    assign bus.busy    = busy_r;
endmodule
